// File: rtl/dram_responder.sv
// dram_responder: on-chip stand-in for the GPU's DRAM slave port.
// Word-addressed backing array with byte-strobed writes and a fixed-latency,
// fully pipelined read path. A free-running refresh FSM periodically drops
// o_ready for a short window to mimic DRAM refresh stalls.
module dram_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_WORDS      = 4096,
  parameter int RD_LATENCY     = 3,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic                    o_ready,
  output logic                    o_rvalid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_err
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
  localparam int CNT_W  = $clog2(CNT_MAX);

  localparam logic [IDX_W-1:0] MEM_WORDS_L   = IDX_W'(MEM_WORDS);
  localparam logic [CNT_W-1:0] PERIOD_LAST   = CNT_W'(REFRESH_PERIOD - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST  = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic {
    NORMAL  = 1'b0,
    REFRESH = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] refresh_cnt;

  // Request decode
  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              accept;
  logic              wr_accept;
  logic              rd_accept;
  logic              unused_addr_bits;

  assign word_idx  = i_addr[ADDR_WIDTH-1:OFF_W];
  assign mem_idx   = word_idx[MEM_AW-1:0];
  assign in_range  = (word_idx < MEM_WORDS_L);
  assign accept    = i_req && o_ready;
  assign wr_accept = accept && i_we;
  assign rd_accept = accept && !i_we;

  // Byte offset within a word carries no information for word accesses.
  assign unused_addr_bits = ^i_addr[OFF_W-1:0];

  // Refresh FSM: counts NORMAL cycles, then holds o_ready low for the refresh window.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NORMAL;
      refresh_cnt <= '0;
      o_ready     <= 1'b1;
    end else begin
      case (state)
        NORMAL: begin
          if (refresh_cnt == PERIOD_LAST) begin
            state       <= REFRESH;
            refresh_cnt <= '0;
            o_ready     <= 1'b0;
          end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        REFRESH: begin
          if (refresh_cnt == REFRESH_LAST) begin
            state       <= NORMAL;
            refresh_cnt <= '0;
            o_ready     <= 1'b1;
          end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        default: begin
          state       <= NORMAL;
          refresh_cnt <= '0;
          o_ready     <= 1'b1;
        end
      endcase
    end
  end

  // Backing array
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Byte-strobed write of in-range words; out-of-range writes are dropped.
  // NOTE: the array has no reset so it maps onto block RAM; contents survive
  // rst and start undefined after power-up.
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wstrb[b]) begin
          mem[mem_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline: stage 0 samples the array at the accept edge, the last
  // stage drives the outputs. Idle slots carry zero data so o_rdata stays 0
  // outside o_rvalid.
  logic [RD_LATENCY-1:0] rd_valid_q;
  logic [RD_LATENCY-1:0] rd_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= '0;
      rd_err_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      rd_valid_q[0] <= rd_accept;
      rd_err_q[0]   <= rd_accept && !in_range;
      rd_data_q[0]  <= (rd_accept && in_range) ? mem[mem_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        rd_err_q[i]   <= rd_err_q[i-1];
        rd_data_q[i]  <= rd_data_q[i-1];
      end
    end
  end

  // One-cycle error pulse for an accepted out-of-range write.
  logic wr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_accept && !in_range;
    end
  end

  assign o_rvalid = rd_valid_q[RD_LATENCY-1];
  assign o_rdata  = rd_data_q[RD_LATENCY-1];
  assign o_err    = rd_err_q[RD_LATENCY-1] | wr_err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: a requester task drives accesses and
// pushes expected read responses into a scoreboard; a negedge monitor pops and
// compares them, including the exact return cycle.
module tb_dram_responder;

  localparam int RD_LAT = 3;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        o_ready;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_err;

  dram_responder dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_we     (i_we),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .i_wstrb  (i_wstrb),
    .o_ready  (o_ready),
    .o_rvalid (o_rvalid),
    .o_rdata  (o_rdata),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset release.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        rd_q [$];
  logic [31:0] model [int];
  int          wr_err_due;
  bit          watch_ready;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Present one request at a negedge, hold it until accepted, update the model.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int acc_cyc);
    int          n;
    int          idx;
    logic        oor;
    logic [31:0] cur;
    i_req   = 1'b1;
    i_we    = we;
    i_addr  = addr;
    i_wdata = wdata;
    i_wstrb = strb;
    n = 0;
    while (!o_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      check("req_timeout", 0, 1);
      i_req   = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    idx = int'(addr >> 2);
    oor = (idx >= 4096);
    if (we) begin
      if (!oor) begin
        cur = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) cur[b*8 +: 8] = wdata[b*8 +: 8];
        end
        model[idx] = cur;
      end else begin
        wr_err_due = cyc + 1;
      end
    end else begin
      rd_q.push_back('{data: oor ? 32'h0 : model[idx], err: oor, due: cyc + RD_LAT});
    end
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    if (o_rvalid) begin
      if (rd_q.size() == 0) begin
        check("spurious_rvalid", 1, 0);
      end else begin
        e = rd_q.pop_front();
        check("rd_cycle", cyc, e.due);
        check("rdata", o_rdata, e.data);
        check("rerr", o_err, e.err);
      end
    end else if (o_err || cyc == wr_err_due) begin
      check("wr_err", o_err, cyc == wr_err_due);
    end
    if (watch_ready && cyc >= 250 && cyc <= 262) begin
      check("ready_window", o_ready, !(cyc >= 256 && cyc <= 259));
    end
  endtask

  initial begin
    int acc;
    n_checks    = 0;
    n_errors    = 0;
    wr_err_due  = -1;
    watch_ready = 1'b0;
    rst     = 1'b1;
    i_req   = 1'b0;
    i_we    = 1'b0;
    i_addr  = '0;
    i_wdata = '0;
    i_wstrb = '0;

    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", o_ready, 1);
    check("rst_rvalid", o_rvalid, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_err", o_err, 0);

    // 1: full write then read-back, back-to-back (no stale read)
    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
    do_req(0, 32'h10, 32'h0, 4'h0, acc);

    // 2: partial write with strobes
    do_req(1, 32'h20, 32'h11223344, 4'hF, acc);
    do_req(1, 32'h20, 32'hAABBCCDD, 4'h5, acc);
    do_req(0, 32'h20, 32'h0, 4'h0, acc);
    repeat (RD_LAT + 1) @(negedge clk);

    // 3: fill four words then four back-to-back reads
    for (int i = 0; i < 4; i++) do_req(1, 32'(i * 4), 32'hC0DE_0000 + 32'(i * 32'h111), 4'hF, acc);
    for (int i = 0; i < 4; i++) do_req(0, 32'(i * 4), 32'h0, 4'h0, acc);
    repeat (RD_LAT + 1) @(negedge clk);

    // 5: out-of-range read and write; word 0 must be untouched by the write
    do_req(0, 32'h4000, 32'h0, 4'h0, acc);
    repeat (RD_LAT + 1) @(negedge clk);
    do_req(1, 32'h4000, 32'hFFFF_FFFF, 4'hF, acc);
    repeat (2) @(negedge clk);
    do_req(0, 32'h0, 32'h0, 4'h0, acc);
    repeat (RD_LAT + 1) @(negedge clk);

    // 4: refresh window at cycles 256..259, reads in the last ready cycles
    watch_ready = 1'b1;
    while (cyc < 254) @(negedge clk);
    do_req(0, 32'h10, 32'h0, 4'h0, acc);
    check("acc_254", acc, 254);
    do_req(0, 32'h20, 32'h0, 4'h0, acc);
    check("acc_255", acc, 255);
    do_req(0, 32'h8, 32'h0, 4'h0, acc);
    check("acc_held", acc, 260);
    repeat (RD_LAT + 4) @(negedge clk);
    watch_ready = 1'b0;

    // 6: reset one cycle after a read accept discards it
    do_req(0, 32'h10, 32'h0, 4'h0, acc);
    #2;
    rst = 1'b1;
    rd_q.delete();
    wr_err_due = -1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_ready", o_ready, 1);
    check("rst2_rvalid", o_rvalid, 0);
    check("rst2_rdata", o_rdata, 0);
    check("rst2_err", o_err, 0);
    repeat (RD_LAT + 4) @(negedge clk);
    // Array contents survive reset
    do_req(0, 32'h20, 32'h0, 4'h0, acc);
    repeat (RD_LAT + 2) @(negedge clk);
    check("drain", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
